// File: rtl/fifo_mac_drain_pkg.sv
// Shared types and defaults for the FIFO-draining dot-product engine.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ACC_WIDTH_DEF = 24;

endpackage

// File: rtl/fifo_mac_drain_mac_stage.sv
// Registered unsigned multiply feeding a wrapping accumulator.
// The accumulator is cleared synchronously at the start of each run.
module mac_stage
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PW = 2 * DATA_WIDTH;

  if (ACC_WIDTH < PW) begin : g_bad_acc_width
    $error("mac_stage: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  logic [PW-1:0] prod_q;
  logic          prod_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else if (clear) begin
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      prod_v <= pop;
      if (pop) begin
        prod_q <= {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
      end
      // Wraps silently modulo 2^ACC_WIDTH.
      if (prod_v) begin
        acc <= acc + ACC_WIDTH'(prod_q);
      end
    end
  end

endmodule

// File: rtl/fifo_mac_drain.sv
// Drains two show-ahead FIFOs in lockstep and accumulates LEN products.
//   state | meaning
//   IDLE  | waiting for start; result holds last sum
//   RUN   | popping both FIFOs together whenever both have data
//   DRAIN | last product enters the accumulator
//   DONE  | result_valid pulse, then back to IDLE
module fifo_mac_drain
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN        = 8,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_empty,
  output logic                  a_rden,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_empty,
  output logic                  b_rden,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid
);

  localparam int CW = $clog2(LEN + 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            pop;
  logic            clear;
  logic [ACC_WIDTH-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        cnt <= '0;
      end else if (pop) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    clear        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        pop  = !a_empty && !b_empty && (cnt < CW'(LEN));
        if (pop && (cnt == CW'(LEN - 1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a_rden = pop;
  assign b_rden = pop;
  assign result = acc;

  mac_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .pop   (pop),
    .a_data(a_data),
    .b_data(b_data),
    .acc   (acc)
  );

endmodule

// File: doc/fifo_mac_drain.md
# fifo_mac_drain

Consumer stage that drains a pair of show-ahead FIFOs (operand A and operand B) in lockstep and multiply-accumulates LEN element pairs into one dot-product result. It sits directly downstream of the minilab FIFO instances: it drives their `rden` and samples their `o_data`/`empty`. It presents the finished sum with a one-cycle valid/done pulse, then holds it until the next run.

## Interface
- `DATA_WIDTH`, 8: width of each FIFO element (unsigned).
- `LEN`, 8: element pairs consumed per run (≥1).
- `ACC_WIDTH`, 24: accumulator and result width. Must be ≥ 2*DATA_WIDTH; narrower values are illegal.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `a_data`  in  DATA_WIDTH  head of FIFO A (show-ahead).
- `a_empty`  in  1  FIFO A empty.
- `a_rden`  out  1  pop FIFO A.
- `b_data`  in  DATA_WIDTH  head of FIFO B.
- `b_empty`  in  1  FIFO B empty.
- `b_rden`  out  1  pop FIFO B.
- `busy`  out  1  high in RUN and DRAIN.
- `result`  out  ACC_WIDTH  accumulated sum; held between runs.
- `result_valid`  out  1  one-cycle pulse when `result` is final.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: if `start`, clear the accumulator, element counter `cnt` and product-valid flag, then go to RUN. `start` in any other state is ignored.
- RUN: `pop = !a_empty && !b_empty && cnt < LEN`.
  - `a_rden = b_rden = pop`, combinational. The two FIFOs are always popped together, never singly.
  - On pop: `prod_q <= a_data * b_data` (full 2*DATA_WIDTH, unsigned), `prod_v <= 1`, `cnt++`. Otherwise `prod_v <= 0`.
  - When the pop with `cnt == LEN-1` occurs, go to DRAIN.
- Accumulate stage, active in every state: if `prod_v`, `acc <= acc + zero-extended prod_q`, mod 2^ACC_WIDTH (silent wrap, no saturation).
- DRAIN: one cycle, in which the last product accumulates. Then go to DONE.
- DONE: `result_valid = 1` for exactly one cycle, then go to IDLE. `result` is driven from `acc` and holds its value until cleared by the next `start`.
- `rden` is never asserted outside RUN, or while either FIFO is empty. Stalls of any length on either FIFO are legal.
- Reset at any time:
  - State goes to IDLE; `acc`, `cnt`, `prod_q`, `prod_v` go to 0.
  - `a_rden`, `b_rden`, `busy`, `result_valid` go low and `result` goes to 0 immediately (asynchronous).
  - A partial run is discarded. FIFO contents already popped are lost.

## Timing
- Cycle 0: `start` sampled in IDLE. Cycle 1: RUN.
- No stalls: pops in cycles 1..LEN, DRAIN in cycle LEN+1, `result_valid` in cycle LEN+2.
- Latency from `start` to `result_valid` = LEN+2 plus the number of stall cycles in RUN.
- Earliest next `start` accepted is the cycle after DONE (IDLE). Back-to-back runs have LEN+3 cycle spacing.
- `a_data`/`b_data` are sampled in the same cycle `rden` is high. This matches the FIFO's combinational head output and one-cycle pointer update.

## Structure
- Package `mac_pkg`: `state_t` enum {IDLE, RUN, DRAIN, DONE}, plus a default-width constant for `ACC_WIDTH`.
- Counter width is `$clog2(LEN+1)`.
- One sub-module is natural: `mac_stage` (registered multiply plus accumulate with a clear input). The FSM and pop logic stay in the top module.

## Test plan
- Basic run, LEN=8, both FIFOs preloaded: A=1..8, B=all 1 → `start` at cycle 0; 8 pops in cycles 1-8; `result`=36 with `result_valid` at cycle 10; `busy` high cycles 1-9.
- Stall: B is empty for 3 cycles after its 4th element, A is full, A=B=2 → no `rden` while B is empty, A is never popped alone; `result`=32, `result_valid` 3 cycles later than the no-stall case.
- Wrap, DATA_WIDTH=8, ACC_WIDTH=16, LEN=8, all operands 255 → `result`=61448 (520200 mod 65536).
- `start` pulsed during RUN and DONE → ignored. One result per run; a second run begins only from IDLE; `acc` is cleared at the new start.
- Reset asserted mid-RUN after 4 pops → `rden`, `busy`, `result_valid`, `result` all go to 0 immediately. A subsequent run on fresh data (A=3, B=4, LEN=8) gives `result`=96.
- Back-to-back runs: `start` the cycle after DONE → the second `result_valid` arrives exactly LEN+3 cycles after the first; the first `result` holds until the second `start`.
